// File: rtl/mem_stage.sv
//==============================================================================
// Module   : mem_stage
// Purpose  : Pipeline memory-access stage: EX/MEM register, data-cache
//            handshake and MEM/WB register. Optional sub-word load
//            extension is enabled by defining MEM_LOAD_EXT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_stage (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ex_valid,
    input  logic [31:0] ex_npc,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_store_data,
    input  logic        ex_dren,
    input  logic        ex_dwen,
    input  logic        ex_jaltype,
    input  logic        ex_reg_wen,
    input  logic        ex_halt,
    input  logic [4:0]  ex_wreg,
    input  logic [1:0]  ex_ldsize,
    input  logic        ex_ldsigned,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_busy,
    output logic        wb_valid,
    output logic        wb_jaltype,
    output logic        wb_ldtype,
    output logic        wb_reg_wen,
    output logic        wb_halt,
    output logic [31:0] wb_npc,
    output logic [31:0] wb_extout,
    output logic [31:0] wb_memreg,
    output logic [4:0]  wb_wreg
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t      r_state;

    logic        r_m_valid;
    logic [31:0] r_m_npc;
    logic [31:0] r_m_alu_out;
    logic [31:0] r_m_store_data;
    logic        r_m_dren;
    logic        r_m_dwen;
    logic        r_m_jaltype;
    logic        r_m_reg_wen;
    logic        r_m_halt;
    logic [4:0]  r_m_wreg;

    logic        r_wb_valid;
    logic        r_wb_jaltype;
    logic        r_wb_ldtype;
    logic        r_wb_reg_wen;
    logic        r_wb_halt;
    logic [31:0] r_wb_npc;
    logic [31:0] r_wb_extout;
    logic [31:0] r_wb_memreg;
    logic [4:0]  r_wb_wreg;

    logic        w_mem_op;
    logic        w_busy;
    logic        w_halt_next;
    logic        w_m_take;
    logic [31:0] w_ext;

    assign w_mem_op    = r_m_valid & (r_m_dren | r_m_dwen);
    assign w_busy      = w_mem_op & ~dhit;
    // Halt status as it will be after the next WB load; anything entering
    // M alongside or after the halt is squashed.
    assign w_halt_next = r_wb_halt | (r_m_valid & r_m_halt);
    assign w_m_take    = ex_valid & ~w_halt_next;

    assign dmemREN   = r_m_dren;
    assign dmemWEN   = r_m_dwen;
    assign dmemaddr  = r_m_alu_out;
    assign dmemstore = r_m_store_data;
    assign mem_busy  = w_busy;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_m_valid      <= 1'b0;
            r_m_npc        <= '0;
            r_m_alu_out    <= '0;
            r_m_store_data <= '0;
            r_m_dren       <= 1'b0;
            r_m_dwen       <= 1'b0;
            r_m_jaltype    <= 1'b0;
            r_m_reg_wen    <= 1'b0;
            r_m_halt       <= 1'b0;
            r_m_wreg       <= '0;
        end else if (!w_busy) begin
            if (w_m_take) begin
                r_m_valid      <= 1'b1;
                r_m_npc        <= ex_npc;
                r_m_alu_out    <= ex_alu_out;
                r_m_store_data <= ex_store_data;
                r_m_dren       <= ex_dren;
                r_m_dwen       <= ex_dwen;
                r_m_jaltype    <= ex_jaltype;
                r_m_reg_wen    <= ex_reg_wen;
                r_m_halt       <= ex_halt;
                r_m_wreg       <= ex_wreg;
            end else begin
                // Bubbles carry all-zero controls so the strobes stay low.
                r_m_valid      <= 1'b0;
                r_m_npc        <= '0;
                r_m_alu_out    <= '0;
                r_m_store_data <= '0;
                r_m_dren       <= 1'b0;
                r_m_dwen       <= 1'b0;
                r_m_jaltype    <= 1'b0;
                r_m_reg_wen    <= 1'b0;
                r_m_halt       <= 1'b0;
                r_m_wreg       <= '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (w_mem_op && !dhit) r_state <= ST_ACCESS;
                ST_ACCESS: if (dhit)              r_state <= ST_IDLE;
                default:                          r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_LOAD_EXT_EN
    logic [1:0]  r_m_ldsize;
    logic        r_m_ldsigned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_m_ldsize   <= 2'b00;
            r_m_ldsigned <= 1'b0;
        end else if (!w_busy) begin
            r_m_ldsize   <= w_m_take ? ex_ldsize   : 2'b00;
            r_m_ldsigned <= w_m_take ? ex_ldsigned : 1'b0;
        end
    end

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        w_byte = 8'h00;
        case (r_m_alu_out[1:0])
            2'd0:    w_byte = dmemload[31:24];
            2'd1:    w_byte = dmemload[23:16];
            2'd2:    w_byte = dmemload[15:8];
            default: w_byte = dmemload[7:0];
        endcase
        w_half = r_m_alu_out[1] ? dmemload[15:0] : dmemload[31:16];
        case (r_m_ldsize)
            2'b10:   w_ext = {{24{r_m_ldsigned & w_byte[7]}}, w_byte};
            2'b01:   w_ext = {{16{r_m_ldsigned & w_half[15]}}, w_half};
            default: w_ext = dmemload;
        endcase
    end
`else
    logic w_unused_ld;

    assign w_ext       = dmemload;
    assign w_unused_ld = ^{ex_ldsize, ex_ldsigned};
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wb_valid   <= 1'b0;
            r_wb_jaltype <= 1'b0;
            r_wb_ldtype  <= 1'b0;
            r_wb_reg_wen <= 1'b0;
            r_wb_halt    <= 1'b0;
            r_wb_npc     <= '0;
            r_wb_extout  <= '0;
            r_wb_memreg  <= '0;
            r_wb_wreg    <= '0;
        end else if (!w_busy) begin
            r_wb_valid   <= r_m_valid;
            r_wb_jaltype <= r_m_jaltype;
            r_wb_ldtype  <= r_m_dren;
            r_wb_reg_wen <= r_m_reg_wen & r_m_valid;
            r_wb_halt    <= w_halt_next;
            r_wb_npc     <= r_m_npc;
            r_wb_extout  <= w_ext;
            r_wb_memreg  <= r_m_alu_out;
            r_wb_wreg    <= r_m_wreg;
        end
    end

    assign wb_valid   = r_wb_valid;
    assign wb_jaltype = r_wb_jaltype;
    assign wb_ldtype  = r_wb_ldtype;
    assign wb_reg_wen = r_wb_reg_wen;
    assign wb_halt    = r_wb_halt;
    assign wb_npc     = r_wb_npc;
    assign wb_extout  = r_wb_extout;
    assign wb_memreg  = r_wb_memreg;
    assign wb_wreg    = r_wb_wreg;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//==============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage with a transaction-level model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ex_valid, ex_dren, ex_dwen, ex_jaltype, ex_reg_wen, ex_halt, ex_ldsigned;
    logic [31:0] ex_npc, ex_alu_out, ex_store_data;
    logic [4:0]  ex_wreg;
    logic [1:0]  ex_ldsize;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN, dmemWEN, mem_busy;
    logic [31:0] dmemaddr, dmemstore;
    logic        wb_valid, wb_jaltype, wb_ldtype, wb_reg_wen, wb_halt;
    logic [31:0] wb_npc, wb_extout, wb_memreg;
    logic [4:0]  wb_wreg;

    mem_stage dut (
        .CLK(CLK), .nRST(nRST),
        .ex_valid(ex_valid), .ex_npc(ex_npc), .ex_alu_out(ex_alu_out),
        .ex_store_data(ex_store_data), .ex_dren(ex_dren), .ex_dwen(ex_dwen),
        .ex_jaltype(ex_jaltype), .ex_reg_wen(ex_reg_wen), .ex_halt(ex_halt),
        .ex_wreg(ex_wreg), .ex_ldsize(ex_ldsize), .ex_ldsigned(ex_ldsigned),
        .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .mem_busy(mem_busy),
        .wb_valid(wb_valid), .wb_jaltype(wb_jaltype), .wb_ldtype(wb_ldtype),
        .wb_reg_wen(wb_reg_wen), .wb_halt(wb_halt), .wb_npc(wb_npc),
        .wb_extout(wb_extout), .wb_memreg(wb_memreg), .wb_wreg(wb_wreg)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        v;
        logic [31:0] npc;
        logic [31:0] alu;
        logic [31:0] sd;
        logic        dren;
        logic        dwen;
        logic        jal;
        logic        wen;
        logic        halt;
        logic [4:0]  wreg;
        logic [1:0]  ldsize;
        logic        ldsigned;
    } ins_t;

    typedef struct packed {
        logic        valid;
        logic        jal;
        logic        ldtype;
        logic        wen;
        logic        halt;
        logic [31:0] npc;
        logic [31:0] ext;
        logic [31:0] memreg;
        logic [4:0]  wreg;
    } wbx_t;

    int   checks = 0;
    int   failures = 0;
    ins_t m;            // instruction the model holds in the memory stage
    wbx_t wb_e;         // expected write-back register
    int   k_c = 1;      // request cycles the current memory op will take
    int   wait_c = 0;
    int   busy_seen = 0;
    int   wen_seen = 0;
    logic        last_wen;
    logic [31:0] last_addr, last_store;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ext_model(input logic [31:0] d, input logic [1:0] size,
                                              input logic sgn, input logic [1:0] off);
        logic [31:0] r;
`ifndef MEM_LOAD_EXT_EN
        return d;
`endif
        if (size == 2'b10) begin
            r = (d >> (8 * (3 - int'(off)))) & 32'h0000_00FF;
            if (sgn && r[7]) r = r | 32'hFFFF_FF00;
            return r;
        end
        if (size == 2'b01) begin
            r = (d >> (off[1] ? 0 : 16)) & 32'h0000_FFFF;
            if (sgn && r[15]) r = r | 32'hFFFF_0000;
            return r;
        end
        return d;
    endfunction

    function automatic ins_t mk(input int kind, input logic [31:0] alu, input logic [31:0] sd,
                                input logic [4:0] wreg, input logic wen);
        ins_t r;
        r          = '0;
        r.v        = 1'b1;
        r.npc      = alu + 32'd4;
        r.alu      = alu;
        r.sd       = sd;
        r.dren     = (kind == 1);
        r.dwen     = (kind == 2);
        r.wreg     = wreg;
        r.wen      = wen;
        return r;
    endfunction

    function automatic ins_t rand_ins();
        ins_t r;
        int   kind;
        kind       = int'($urandom_range(0, 2));
        r          = '0;
        r.v        = ($urandom_range(0, 3) != 0);
        r.npc      = $urandom;
        r.alu      = $urandom;
        r.sd       = $urandom;
        r.dren     = (kind == 1);
        r.dwen     = (kind == 2);
        r.jal      = $urandom_range(0, 1) == 1;
        r.wen      = $urandom_range(0, 1) == 1;
        r.wreg     = 5'($urandom_range(0, 31));
        r.ldsize   = 2'($urandom_range(0, 2));
        r.ldsigned = $urandom_range(0, 1) == 1;
        return r;
    endfunction

    // One clock cycle: drive at negedge, check the request side, clock, check WB.
    task automatic cycle(input ins_t e, input bit auto_hit, input bit dh_in, input logic [31:0] dl);
        bit memop, dh, busy_e;
        @(negedge CLK);
        memop = m.v && (m.dren || m.dwen);
        if (auto_hit) dh = memop ? (wait_c == k_c - 1) : ($urandom_range(0, 1) == 1);
        else          dh = dh_in;
        ex_valid = e.v; ex_npc = e.npc; ex_alu_out = e.alu; ex_store_data = e.sd;
        ex_dren = e.dren; ex_dwen = e.dwen; ex_jaltype = e.jal; ex_reg_wen = e.wen;
        ex_halt = e.halt; ex_wreg = e.wreg; ex_ldsize = e.ldsize; ex_ldsigned = e.ldsigned;
        dhit = dh; dmemload = dl;
        #1;
        busy_e = memop && !dh;
        chk("mem_busy", mem_busy, busy_e);
        chk("dmemREN", dmemREN, m.v & m.dren);
        chk("dmemWEN", dmemWEN, m.v & m.dwen);
        chk("dmemaddr", dmemaddr, m.alu);
        chk("dmemstore", dmemstore, m.sd);
        if (mem_busy === 1'b1) busy_seen++;
        if (dmemWEN === 1'b1) wen_seen++;
        last_wen = dmemWEN; last_addr = dmemaddr; last_store = dmemstore;
        @(posedge CLK);
        #1;
        if (!busy_e) begin
            wb_e.valid  = m.v;
            wb_e.jal    = m.jal;
            wb_e.ldtype = m.dren;
            wb_e.wen    = m.wen & m.v;
            wb_e.halt   = wb_e.halt | (m.v & m.halt);
            wb_e.npc    = m.npc;
            wb_e.ext    = ext_model(dl, m.ldsize, m.ldsigned, m.alu[1:0]);
            wb_e.memreg = m.alu;
            wb_e.wreg   = m.wreg;
            m      = (e.v && !wb_e.halt) ? e : '0;
            k_c    = int'($urandom_range(1, 4));
            wait_c = 0;
        end else begin
            wait_c++;
        end
        chk("wb_valid", wb_valid, wb_e.valid);
        chk("wb_jaltype", wb_jaltype, wb_e.jal);
        chk("wb_ldtype", wb_ldtype, wb_e.ldtype);
        chk("wb_reg_wen", wb_reg_wen, wb_e.wen);
        chk("wb_halt", wb_halt, wb_e.halt);
        chk("wb_npc", wb_npc, wb_e.npc);
        chk("wb_extout", wb_extout, wb_e.ext);
        chk("wb_memreg", wb_memreg, wb_e.memreg);
        chk("wb_wreg", wb_wreg, wb_e.wreg);
    endtask

    initial begin
        ins_t bub, op;
        bub = '0; m = '0; wb_e = '0;
        ex_valid = 0; ex_npc = 0; ex_alu_out = 0; ex_store_data = 0; ex_dren = 0;
        ex_dwen = 0; ex_jaltype = 0; ex_reg_wen = 0; ex_halt = 0; ex_wreg = 0;
        ex_ldsize = 0; ex_ldsigned = 0; dhit = 0; dmemload = 0;
        nRST = 1'b1;
        #1 nRST = 1'b0;
        #2;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_reg_wen", wb_reg_wen, 0);
        chk("rst_wb_halt", wb_halt, 0);
        chk("rst_busy", mem_busy, 0);
        chk("rst_ren", dmemREN, 0);
        chk("rst_wen", dmemWEN, 0);
        chk("rst_memreg", wb_memreg, 0);
        @(negedge CLK);
        nRST = 1'b1;

        // ALU stream r1..r3
        busy_seen = 0;
        cycle(mk(0, 32'h11, 0, 5'd1, 1'b1), 0, 0, 32'h0);
        cycle(mk(0, 32'h22, 0, 5'd2, 1'b1), 0, 0, 32'h0);
        chk("alu_wb1", wb_memreg, 32'h11);
        cycle(mk(0, 32'h33, 0, 5'd3, 1'b1), 0, 0, 32'h0);
        chk("alu_wb2", wb_memreg, 32'h22);
        cycle(bub, 0, 0, 32'h0);
        chk("alu_wb3", wb_memreg, 32'h33);
        chk("alu_wreg3", wb_wreg, 5'd3);
        chk("alu_no_busy", busy_seen, 0);

        // lw 0x100 with hit in third request cycle; stall-cycle inputs ignored
        busy_seen = 0;
        cycle(mk(1, 32'h100, 0, 5'd4, 1'b1), 0, 0, 32'h0);
        cycle(mk(0, 32'h999, 0, 5'd9, 1'b1), 0, 0, 32'h1234);
        cycle(mk(0, 32'h998, 0, 5'd9, 1'b1), 0, 0, 32'h5678);
        cycle(bub, 0, 1, 32'hDEADBEEF);
        chk("lw_busy_cycles", busy_seen, 2);
        chk("lw_extout", wb_extout, 32'hDEADBEEF);
        chk("lw_ldtype", wb_ldtype, 1);
        chk("lw_reg_wen", wb_reg_wen, 1);

        // sw 0x200, same-cycle hit
        busy_seen = 0; wen_seen = 0;
        cycle(mk(2, 32'h200, 32'hCAFEF00D, 5'd0, 1'b0), 0, 0, 32'h0);
        cycle(bub, 0, 1, 32'h0);
        chk("sw_wen", last_wen, 1);
        chk("sw_addr", last_addr, 32'h200);
        chk("sw_data", last_store, 32'hCAFEF00D);
        chk("sw_reg_wen", wb_reg_wen, 0);
        cycle(bub, 0, 0, 32'h0);
        chk("sw_wen_cycles", wen_seen, 1);
        chk("sw_no_busy", busy_seen, 0);

`ifdef MEM_LOAD_EXT_EN
        op = mk(1, 32'h400, 0, 5'd5, 1'b1); op.ldsize = 2'b10; op.ldsigned = 1'b1;
        cycle(op, 0, 0, 32'h0);
        op = mk(1, 32'h403, 0, 5'd6, 1'b1); op.ldsize = 2'b10; op.ldsigned = 1'b0;
        cycle(op, 0, 1, 32'h80FF7F01);
        chk("lb_off0", wb_extout, 32'hFFFFFF80);
        op = mk(1, 32'h402, 0, 5'd7, 1'b1); op.ldsize = 2'b01; op.ldsigned = 1'b1;
        cycle(op, 0, 1, 32'h80FF7F01);
        chk("lbu_off3", wb_extout, 32'h00000001);
        cycle(bub, 0, 1, 32'h80FF7F01);
        chk("lh_off2", wb_extout, 32'h00007F01);
`endif

        // Asynchronous reset during an outstanding load
        cycle(mk(0, 32'h55, 0, 5'd5, 1'b1), 0, 0, 32'h0);
        cycle(mk(1, 32'h300, 0, 5'd6, 1'b1), 0, 0, 32'h0);
        @(negedge CLK);
        ex_valid = 0; dhit = 0;
        #1;
        chk("prerst_ren", dmemREN, 1);
        chk("prerst_wb_valid", wb_valid, 1);
        nRST = 1'b0;
        #1;
        chk("midrst_ren", dmemREN, 0);
        chk("midrst_busy", mem_busy, 0);
        chk("midrst_wb_valid", wb_valid, 0);
        m = '0; wb_e = '0; wait_c = 0;
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        busy_seen = 0;
        cycle(mk(1, 32'h104, 0, 5'd8, 1'b1), 0, 1, 32'h0);
        cycle(bub, 0, 1, 32'h12345678);
        chk("postrst_load", wb_extout, 32'h12345678);
        chk("postrst_no_busy", busy_seen, 0);

        // Randomized stream against the model
        for (int i = 0; i < 400; i++) cycle(rand_ins(), 1, 0, $urandom);
        for (int i = 0; i < 6; i++) cycle(bub, 1, 0, $urandom);

        // Halt followed by two valid ops
        op = mk(0, 32'h77, 0, 5'd10, 1'b0); op.halt = 1'b1;
        cycle(op, 1, 0, 32'h0);
        cycle(mk(0, 32'h88, 0, 5'd11, 1'b1), 1, 0, 32'h0);
        chk("halt_set", wb_halt, 1);
        chk("halt_wb_valid", wb_valid, 1);
        cycle(mk(1, 32'h99, 0, 5'd12, 1'b1), 1, 0, 32'h0);
        chk("halt_bub1_valid", wb_valid, 0);
        chk("halt_bub1_wen", wb_reg_wen, 0);
        cycle(bub, 1, 0, 32'h0);
        chk("halt_bub2_valid", wb_valid, 0);
        chk("halt_bub2_wen", wb_reg_wen, 0);
        chk("halt_sticky", wb_halt, 1);
        cycle(mk(0, 32'hAA, 0, 5'd13, 1'b1), 1, 0, 32'h0);
        cycle(bub, 1, 0, 32'h0);
        chk("halt_sticky2", wb_halt, 1);
        chk("halt_bub3_wen", wb_reg_wen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
